vga_rx: RTL and testbench
=========================

Name: vga_rx

Overview:
- Receive-side counterpart of the 640x480 VGA generator.
- Samples incoming hsync/vsync/RGB on the pixel-clock enable and recovers horizontal/vertical position.
- Checks line and frame timing against 640x480@60 totals and runs a lock FSM.
- Emits one qualified pixel strobe with coordinates and colour per active pixel. Used as loopback checker and capture front-end.

Parameters:
- H_TOTAL, 800, pixel ticks per line
- H_ACT_START, 144, ticks from hsync falling edge to first active pixel (sync 96 + back porch 48)
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_ACT_START, 35, lines from frame start to first active line (sync 2 + back porch 33)
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- clk  in  1  system clock
- i_sclr  in  1  reset, asynchronous, active-high
- i_px_clk  in  1  pixel-clock enable, one clk cycle wide
- i_hsync  in  1  horizontal sync, active low
- i_vsync  in  1  vertical sync, active low
- i_red, i_green, i_blue  in  4 each  pixel colour
- o_px_valid  out  1  one-cycle strobe: active pixel present on outputs
- o_x  out  10  pixel column 0..639
- o_y  out  10  pixel row 0..479
- o_red, o_green, o_blue  out  4 each  registered colour of strobed pixel
- o_frame_start  out  1  one-cycle pulse at each frame start while LOCKED
- o_locked  out  1  FSM is in LOCKED
- o_line_err  out  1  one-cycle pulse: bad line length
- o_frame_err  out  1  one-cycle pulse: bad line count

Behaviour:
- Reset: every output 0; all counters 0; sync history registers 1 (idle high); FSM = UNLOCKED. Reset asserted mid-frame aborts immediately; no pulse is emitted.
- Inputs are registered only on cycles with i_px_clk=1. All state updates occur only on those cycles.
- hsync edge (hfe): registered hsync goes 1->0 between consecutive strobes. vsync edge (vfe): same rule for vsync.
- hcnt (10b):
  - On hfe: check hcnt == H_TOTAL-1, then hcnt <= 0.
  - Otherwise hcnt+1, saturating at 1023.
  - Mismatch pulses o_line_err, except in UNLOCKED before the first hfe.
- vfe sets frame_pend. The next hfe (or a coincident one) is the frame start:
  - check vcnt == V_TOTAL-1 (mismatch pulses o_frame_err);
  - then vcnt <= 0 and frame_pend cleared.
- Other hfe increment vcnt (10b), saturating at 1023.
- Active window: H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE and V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE.
  - o_x = hcnt-H_ACT_START; o_y = vcnt-V_ACT_START.
  - o_px_valid = window && LOCKED.
- Latency: o_px_valid, o_x, o_y and o_r/g/b are valid exactly 1 clk after the strobe cycle that sampled the pixel, for 1 clk only.
- o_frame_start: high in the same cycle as the frame-start counter update is visible, i.e. 1 clk after the strobe.
- FSM:
  - UNLOCKED: on frame start -> ACQUIRE, good <= 0, frame_bad <= 0.
  - ACQUIRE:
    - line error sets frame_bad.
    - At frame start, if frame_bad or vcnt mismatch: good <= 0, stay in ACQUIRE.
    - Otherwise good+1; when good+1 == LOCK_FRAMES -> LOCKED.
    - frame_bad is cleared at every frame start.
  - LOCKED: any o_line_err or o_frame_err -> UNLOCKED in the same update. o_locked drops 1 clk after the error strobe, and o_px_valid is suppressed from that pixel on.
- Simultaneous hfe and vfe: the frame starts at that strobe.
- vfe while frame_pend is already set: ignored, no error.
- Missing hsync: hcnt saturates at 1023, so the next hfe reports o_line_err.

Decomposition:
- Package vga_timing_pkg holds the H_*/V_* constants and the FSM state encoding (UNLOCKED, ACQUIRE, LOCKED). The same constants are shared with the hsync/vsync generators so both ends stay consistent.
- One sub-module, sync_edge_det: strobe-qualified register plus falling-edge detect. Instantiated twice, once for hsync and once for vsync.

Test Plan:
- Drive nominal 640x480 timing from the generator, with px strobe every 4th clk, for 3 frames.
  - o_locked rises at the 3rd frame start (frame start 1 -> ACQUIRE, then 2 good frames).
  - After lock: exactly 307200 o_px_valid strobes per frame.
  - First strobe: x=0, y=0. Last strobe: x=639, y=479.
- Colour pattern R=x[3:0], G=y[3:0], B=4'hA, while locked.
  - Every strobe carries matching colour, 1 clk after its sampling strobe.
- While locked, shorten one line to 799 ticks.
  - o_line_err pulses once; o_locked falls the next clk; no further o_px_valid.
  - Relock after 2 further clean frames following the next frame start.
- Frame with 524 lines while in ACQUIRE.
  - o_frame_err pulses; the good count is reset; lock is delayed by one frame.
- Assert i_sclr asynchronously mid-line (not aligned to clk).
  - All outputs are 0 immediately.
  - After release, no o_line_err or o_frame_err before the first full line, and lock occurs after 3 frame starts.
- Hold hsync low (no edges) for 2000 strobes.
  - No hfe is detected; hcnt holds at 1023.
  - The first subsequent edge produces o_line_err.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants shared by the sync generators
// and the receiver, lock FSM state encoding and a saturating counter helper.
package vga_timing_pkg;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_ACT_START = 144;
  localparam int H_ACTIVE    = 640;
  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 35;
  localparam int V_ACTIVE    = 480;
  localparam int LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: holds the last strobe-sampled level of an active-low sync
// input and flags a 1->0 transition on the strobe that samples the low level.
//   clk     system clock
//   rst     asynchronous active-high reset (history resets to idle high)
//   px_en   pixel-clock enable
//   sync_in raw sync input
//   fall    combinational: high on the strobe cycle that sees the falling edge
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic px_en,
  input  logic sync_in,
  output logic fall
);

  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sync_q <= 1'b1;
    else if (px_en) sync_q <= sync_in;
  end

  assign fall = px_en & sync_q & ~sync_in;

endmodule

// File: rtl/vga_rx.sv
// vga_rx: VGA receiver. Recovers pixel position from hsync/vsync, checks line
// and frame lengths, runs a lock FSM and emits one strobe per active pixel.
//   clk, i_sclr          clock, asynchronous active-high reset
//   i_px_clk             pixel-clock enable (one clk wide)
//   i_hsync, i_vsync     active-low syncs
//   i_red/green/blue     pixel colour
//   o_px_valid, o_x, o_y, o_red/green/blue   active pixel, 1 clk after strobe
//   o_frame_start        frame start pulse while locked
//   o_locked             lock FSM in LOCKED
//   o_line_err, o_frame_err  timing error pulses
//
// state    | meaning
// UNLOCKED | waiting for a frame start
// ACQUIRE  | counting consecutive clean frames
// LOCKED   | timing trusted, pixels are emitted
module vga_rx
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [3:0] i_red,
  input  logic [3:0] i_green,
  input  logic [3:0] i_blue,
  output logic       o_px_valid,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_line_err,
  output logic       o_frame_err
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_A0   = 10'(H_ACT_START);
  localparam logic [9:0] H_A1   = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] V_A0   = 10'(V_ACT_START);
  localparam logic [9:0] V_A1   = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic        hfe, vfe;
  logic [9:0]  hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic        frame_pend, frame_pend_nxt, seen_hfe;
  logic        frame_start, line_err, frame_err, window;
  lock_state_t state, state_nxt;
  logic [3:0]  good, good_nxt;
  logic        frame_bad, frame_bad_nxt;

  sync_edge_det u_hs_edge (
    .clk     (clk),
    .rst     (i_sclr),
    .px_en   (i_px_clk),
    .sync_in (i_hsync),
    .fall    (hfe)
  );

  sync_edge_det u_vs_edge (
    .clk     (clk),
    .rst     (i_sclr),
    .px_en   (i_px_clk),
    .sync_in (i_vsync),
    .fall    (vfe)
  );

  // Position tracking; edges are already strobe-qualified.
  always_comb begin
    hcnt_nxt       = hfe ? 10'd0 : sat_inc10(hcnt);
    // The first hfe after reset has no preceding line to measure.
    line_err       = hfe & seen_hfe & (hcnt != H_LAST);
    // A pending vfe (or a coincident one) makes the next hfe the frame start.
    frame_start    = hfe & (frame_pend | vfe);
    frame_err      = frame_start & (vcnt != V_LAST);
    vcnt_nxt       = vcnt;
    frame_pend_nxt = frame_pend;
    if (frame_start) begin
      vcnt_nxt       = 10'd0;
      frame_pend_nxt = 1'b0;
    end else begin
      if (hfe) vcnt_nxt = sat_inc10(vcnt);
      if (vfe) frame_pend_nxt = 1'b1;
    end
    window = (hcnt_nxt >= H_A0) && (hcnt_nxt < H_A1) &&
             (vcnt_nxt >= V_A0) && (vcnt_nxt < V_A1);
  end

  always_comb begin
    state_nxt     = state;
    good_nxt      = good;
    frame_bad_nxt = frame_bad;
    case (state)
      UNLOCKED: begin
        if (frame_start) begin
          state_nxt     = ACQUIRE;
          good_nxt      = 4'd0;
          frame_bad_nxt = 1'b0;
        end
      end
      ACQUIRE: begin
        if (frame_start) begin
          // A line error on the frame's closing hsync still counts against it.
          frame_bad_nxt = 1'b0;
          if (frame_bad | line_err | frame_err) begin
            good_nxt = 4'd0;
          end else begin
            good_nxt = good + 4'd1;
            if (good + 4'd1 == LOCK_N) state_nxt = LOCKED;
          end
        end else if (line_err) begin
          frame_bad_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (line_err | frame_err) state_nxt = UNLOCKED;
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      state     <= UNLOCKED;
      good      <= 4'd0;
      frame_bad <= 1'b0;
    end else if (i_px_clk) begin
      state     <= state_nxt;
      good      <= good_nxt;
      frame_bad <= frame_bad_nxt;
    end
  end

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      hcnt          <= 10'd0;
      vcnt          <= 10'd0;
      frame_pend    <= 1'b0;
      seen_hfe      <= 1'b0;
      o_px_valid    <= 1'b0;
      o_x           <= 10'd0;
      o_y           <= 10'd0;
      o_red         <= 4'd0;
      o_green       <= 4'd0;
      o_blue        <= 4'd0;
      o_frame_start <= 1'b0;
      o_line_err    <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_px_valid    <= 1'b0;
      o_frame_start <= 1'b0;
      o_line_err    <= 1'b0;
      o_frame_err   <= 1'b0;
      if (i_px_clk) begin
        hcnt          <= hcnt_nxt;
        vcnt          <= vcnt_nxt;
        frame_pend    <= frame_pend_nxt;
        seen_hfe      <= seen_hfe | hfe;
        // Gated on the next state so an erroring pixel is already suppressed.
        o_px_valid    <= window & (state_nxt == LOCKED);
        o_x           <= hcnt_nxt - H_A0;
        o_y           <= vcnt_nxt - V_A0;
        o_red         <= i_red;
        o_green       <= i_green;
        o_blue        <= i_blue;
        o_frame_start <= frame_start & (state_nxt == LOCKED);
        o_line_err    <= line_err;
        o_frame_err   <= frame_err;
      end
    end
  end

  assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: drives a scaled-down VGA timing (same structure as 640x480, small
// totals) with random strobe spacing and random blanking colours, and checks
// the receiver against a behavioural model of position, error and lock rules.
module tb_vga_rx;

  localparam int HT  = 20;  // ticks per line
  localparam int HS  = 3;   // hsync width
  localparam int HAS = 6;   // first active tick after hsync fall
  localparam int HA  = 12;
  localparam int VT  = 12;  // lines per frame
  localparam int VS  = 2;   // vsync width in lines
  localparam int VAS = 4;
  localparam int VA  = 6;
  localparam int LF  = 2;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_px_clk, i_hsync, i_vsync;
  logic [3:0] i_red, i_green, i_blue;
  logic       o_px_valid, o_frame_start, o_locked, o_line_err, o_frame_err;
  logic [9:0] o_x, o_y;
  logic [3:0] o_red, o_green, o_blue;

  vga_rx #(
    .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_px_valid(o_px_valid), .o_x(o_x), .o_y(o_y),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_frame_start(o_frame_start), .o_locked(o_locked),
    .o_line_err(o_line_err), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: ticks since last hsync fall, lines since frame start,
  // and a lock mode (0 unlocked, 1 acquiring, 2 locked) with a clean-frame tally.
  int   m_hpos, m_vpos, m_mode, m_good;
  bit   m_prev_hs, m_prev_vs, m_seen_hs, m_vpend, m_bad;
  bit   exp_valid, exp_locked, exp_le, exp_fe, exp_fs;
  int   exp_x, exp_y;
  logic [11:0] exp_rgb;

  // Per-phase observations of the DUT.
  int   n_valid, n_lerr, n_ferr, first_x, first_y, last_x, last_y;
  bit   got_first;

  task automatic model_reset();
    m_hpos = 0; m_vpos = 0; m_mode = 0; m_good = 0;
    m_prev_hs = 1; m_prev_vs = 1; m_seen_hs = 0; m_vpend = 0; m_bad = 0;
    exp_locked = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [11:0] rgb);
    bit hfe, vfe;
    hfe = m_prev_hs && !hs;
    vfe = m_prev_vs && !vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    exp_le = 0; exp_fe = 0; exp_fs = 0;
    if (hfe) begin
      exp_le = m_seen_hs && (m_hpos != HT - 1);
      m_seen_hs = 1;
      m_hpos = 0;
    end else begin
      m_hpos = (m_hpos < 1023) ? m_hpos + 1 : 1023;
    end
    if (hfe && (m_vpend || vfe)) begin
      exp_fs = 1;
      exp_fe = (m_vpos != VT - 1);
      m_vpos = 0;
      m_vpend = 0;
    end else begin
      if (hfe) m_vpos = (m_vpos < 1023) ? m_vpos + 1 : 1023;
      if (vfe) m_vpend = 1;
    end
    if (m_mode == 0) begin
      if (exp_fs) begin m_mode = 1; m_good = 0; m_bad = 0; end
    end else if (m_mode == 1) begin
      if (exp_le) m_bad = 1;
      if (exp_fs) begin
        if (m_bad || exp_fe) m_good = 0;
        else begin
          m_good++;
          if (m_good == LF) m_mode = 2;
        end
        m_bad = 0;
      end
    end else begin
      if (exp_le || exp_fe) m_mode = 0;
    end
    exp_locked = (m_mode == 2);
    exp_fs     = exp_fs && exp_locked;
    exp_valid  = exp_locked && m_hpos >= HAS && m_hpos < HAS + HA &&
                 m_vpos >= VAS && m_vpos < VAS + VA;
    exp_x   = m_hpos - HAS;
    exp_y   = m_vpos - VAS;
    exp_rgb = rgb;
  endtask

  task automatic stats_clear();
    n_valid = 0; n_lerr = 0; n_ferr = 0; got_first = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
  endtask

  task automatic check_strobe();
    check_eq("px_valid", o_px_valid, exp_valid);
    check_eq("locked", o_locked, exp_locked);
    check_eq("line_err", o_line_err, exp_le);
    check_eq("frame_err", o_frame_err, exp_fe);
    check_eq("frame_start", o_frame_start, exp_fs);
    if (exp_valid) begin
      check_eq("x", o_x, 64'(exp_x));
      check_eq("y", o_y, 64'(exp_y));
      check_eq("rgb", {o_red, o_green, o_blue}, exp_rgb);
    end
    if (o_px_valid) begin
      if (!got_first) begin first_x = o_x; first_y = o_y; got_first = 1; end
      last_x = o_x; last_y = o_y;
      n_valid++;
    end
    if (o_line_err)  n_lerr++;
    if (o_frame_err) n_ferr++;
  endtask

  task automatic gen_tick(input bit hs, input bit vs, input logic [11:0] rgb);
    int gap;
    gap = $urandom_range(1, 3);
    repeat (gap) begin
      @(negedge clk);
      i_px_clk = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_pulses", {o_px_valid, o_line_err, o_frame_err, o_frame_start}, 64'd0);
      check_eq("idle_locked", o_locked, exp_locked);
    end
    @(negedge clk);
    i_px_clk = 1'b1;
    i_hsync  = hs;
    i_vsync  = vs;
    {i_red, i_green, i_blue} = rgb;
    model_step(hs, vs, rgb);
    @(posedge clk); #1;
    check_strobe();
  endtask

  function automatic logic [11:0] rand_rgb();
    return 12'($urandom);
  endfunction

  // Ticks of one frame with index in [t_start, t_stop); t_stop < 0 = to the end.
  task automatic run_frame(input int nlines, input int short_line, input int t_start, input int t_stop);
    int t, len;
    logic [11:0] rgb;
    t = 0;
    for (int v = 0; v < nlines; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        if (t == t_stop) return;
        if (t >= t_start) begin
          if (h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA)
            rgb = {4'(h - HAS), 4'(v - VAS), 4'hA};
          else
            rgb = rand_rgb();
          gen_tick(h >= HS, v >= VS, rgb);
        end
        t++;
      end
    end
  endtask

  task automatic frame(input int nlines, input int short_line);
    stats_clear();
    run_frame(nlines, short_line, 0, -1);
  endtask

  task automatic check_full_frame(input string tag);
    check_eq({tag, "_count"}, 64'(n_valid), 64'(HA * VA));
    check_eq({tag, "_first"}, {32'(first_x), 32'(first_y)}, {32'd0, 32'd0});
    check_eq({tag, "_last"}, {32'(last_x), 32'(last_y)}, {32'(HA - 1), 32'(VA - 1)});
  endtask

  initial begin
    i_px_clk = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
    i_red = 4'd0; i_green = 4'd0; i_blue = 4'd0;
    model_reset();
    stats_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {o_px_valid, o_x, o_y, o_red, o_green, o_blue,
                            o_frame_start, o_locked, o_line_err, o_frame_err}, 64'd0);
    i_sclr = 1'b0;

    // Nominal timing: frame starts 1 (acquire), 2, 3 (lock).
    frame(VT, -1);
    frame(VT, -1);
    check_eq("f1_not_locked", o_locked, 1'b0);
    frame(VT, -1);
    check_eq("f2_locked", o_locked, 1'b1);
    check_full_frame("f2");

    // One 19-tick line while locked.
    frame(VT, 1);
    check_eq("short_line_errs", 64'(n_lerr), 64'd1);
    check_eq("short_line_valid", 64'(n_valid), 64'd0);
    check_eq("short_line_unlock", o_locked, 1'b0);
    frame(VT, -1);
    frame(VT, -1);
    check_eq("relock_pending", o_locked, 1'b0);
    frame(VT, -1);
    check_eq("relocked", o_locked, 1'b1);
    check_full_frame("f6");

    // hsync held low for 2000 strobes.
    frame(VT, -1);
    stats_clear();
    repeat (2000) gen_tick(1'b0, 1'b1, rand_rgb());
    repeat (4) gen_tick(1'b1, 1'b1, rand_rgb());
    check_eq("stuck_no_err", 64'(n_lerr + n_ferr), 64'd0);
    frame(VT, -1);
    check_eq("stuck_line_err", 64'(n_lerr), 64'd1);
    check_eq("stuck_frame_err", 64'(n_ferr), 64'd1);
    check_eq("stuck_unlock", o_locked, 1'b0);

    // Short frame while acquiring delays lock by one frame.
    frame(VT - 1, -1);
    frame(VT, -1);
    check_eq("short_frame_err", 64'(n_ferr), 64'd1);
    frame(VT, -1);
    check_eq("short_frame_delay", o_locked, 1'b0);
    frame(VT, -1);
    check_eq("short_frame_relock", o_locked, 1'b1);

    // Asynchronous reset mid-line, off the clock edge.
    stats_clear();
    run_frame(VT, -1, 0, 5 * HT + 10);
    @(negedge clk);
    i_px_clk = 1'b0;
    #3 i_sclr = 1'b1;
    #1;
    check_eq("async_rst_outs", {o_px_valid, o_x, o_y, o_red, o_green, o_blue,
                                o_frame_start, o_locked, o_line_err, o_frame_err}, 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    i_sclr = 1'b0;
    stats_clear();
    run_frame(VT, -1, 5 * HT + 10, -1);
    check_eq("post_rst_no_err", 64'(n_lerr + n_ferr), 64'd0);
    frame(VT, -1);
    frame(VT, -1);
    check_eq("post_rst_pending", o_locked, 1'b0);
    frame(VT, -1);
    check_eq("post_rst_locked", o_locked, 1'b1);
    check_full_frame("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
